// File: rtl/except_arbiter.sv
// Memory-stage exception arbiter: picks the oldest excepting lane or a pending
// interrupt, computes the handler vector / ERET target, flushes, then holds a
// redirect to fetch until it is accepted.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   lane_* (inputs)            per-lane valid/pc/delayslot/exc/code/badva/refill/eret
//   irq_hw, irq_sw             async hardware lines, software IP[1:0]
//   status_*, cause_iv, ebase,
//   epc, error_epc             CP0 state used for vector/target selection
//   redirect_ready             fetch accepts the redirect
//   flush, kill_mask           one-cycle squash pulse and lanes to squash
//   redirect_valid/_pc         held redirect request
//   exc_*                      CP0 update record for the winning event
//   busy                       request outstanding
module except_arbiter #(
  parameter int  N_LANES     = 2,
  parameter int  IRQ_W       = 6,
  parameter int  SYNC_STAGES = 2,
  localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1,
  localparam int PW = IRQ_W + 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_LANES-1:0]    lane_valid,
  input  logic [32*N_LANES-1:0] lane_pc,
  input  logic [N_LANES-1:0]    lane_delayslot,
  input  logic [N_LANES-1:0]    lane_exc,
  input  logic [5*N_LANES-1:0]  lane_code,
  input  logic [32*N_LANES-1:0] lane_badva,
  input  logic [N_LANES-1:0]    lane_refill,
  input  logic [N_LANES-1:0]    lane_eret,
  input  logic [IRQ_W-1:0]      irq_hw,
  input  logic [1:0]            irq_sw,
  input  logic [PW-1:0]         status_im,
  input  logic                  status_ie,
  input  logic                  status_exl,
  input  logic                  status_erl,
  input  logic                  status_bev,
  input  logic                  cause_iv,
  input  logic [19:0]           ebase,
  input  logic [31:0]           epc,
  input  logic [31:0]           error_epc,
  input  logic                  redirect_ready,
  output logic                  flush,
  output logic [N_LANES-1:0]    kill_mask,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  output logic [4:0]            exc_code,
  output logic [31:0]           exc_pc,
  output logic [31:0]           exc_badva,
  output logic                  exc_delayslot,
  output logic                  exc_eret,
  output logic [PW-1:0]         exc_ip,
  output logic [LW-1:0]         exc_lane,
  output logic                  busy
);

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_e;

  // Interrupt synchroniser
  logic [SYNC_STAGES-1:0][IRQ_W-1:0] sync_q;
  logic [IRQ_W-1:0]                  irq_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_hw};
    end
  end

  assign irq_s = sync_q[SYNC_STAGES-1];

  logic [PW-1:0] pend;
  logic          int_ok;

  assign pend   = {irq_s, irq_sw} & status_im;
  assign int_ok = status_ie & ~status_exl & ~status_erl & (|pend);

  // Lane selection: descending scan leaves the lowest index
  logic [N_LANES-1:0] cand;
  logic               e_found;
  logic               i_found;
  logic [LW-1:0]      e_idx;
  logic [LW-1:0]      i_idx;

  assign cand = lane_valid & (lane_exc | lane_eret);

  always_comb begin
    e_found = 1'b0;
    i_found = 1'b0;
    e_idx   = '0;
    i_idx   = '0;
    for (int k = N_LANES - 1; k >= 0; k--) begin
      if (cand[k]) begin
        e_found = 1'b1;
        e_idx   = LW'(k);
      end
      if (lane_valid[k]) begin
        i_found = 1'b1;
        i_idx   = LW'(k);
      end
    end
  end

  logic          win_int;
  logic          win_any;
  logic [LW-1:0] w_idx;

  assign win_int = int_ok & i_found & (~e_found | (i_idx <= e_idx));
  assign win_any = win_int | e_found;
  assign w_idx   = win_int ? i_idx : e_idx;

  // Winning lane fields
  logic [31:0] l_pc;
  logic [31:0] l_badva;
  logic [4:0]  l_code;
  logic        l_ds;
  logic        l_exc;
  logic        l_eret;
  logic        l_refill;

  always_comb begin
    l_pc     = '0;
    l_badva  = '0;
    l_code   = '0;
    l_ds     = 1'b0;
    l_exc    = 1'b0;
    l_eret   = 1'b0;
    l_refill = 1'b0;
    for (int k = 0; k < N_LANES; k++) begin
      if (w_idx == LW'(k)) begin
        l_pc     = lane_pc[32*k +: 32];
        l_badva  = lane_badva[32*k +: 32];
        l_code   = lane_code[5*k +: 5];
        l_ds     = lane_delayslot[k];
        l_exc    = lane_exc[k];
        l_eret   = lane_eret[k];
        l_refill = lane_refill[k];
      end
    end
  end

  // Record contents; exception beats ERET on the same lane
  logic        w_exc;
  logic        w_eret;
  logic [4:0]  w_code;
  logic [31:0] w_badva;
  logic [PW-1:0] w_ip;
  logic [11:0] w_off;
  logic [31:0] w_base;
  logic [31:0] w_target;
  logic [N_LANES-1:0] w_kill;

  assign w_exc   = ~win_int & l_exc;
  assign w_eret  = ~win_int & ~l_exc & l_eret;
  assign w_code  = w_exc ? l_code : 5'd0;
  assign w_badva = w_exc ? l_badva : 32'd0;
  assign w_ip    = win_int ? pend : '0;

  always_comb begin
    w_off = 12'h180;
    if (!status_exl && w_exc && l_refill &&
        (w_code == 5'd2 || w_code == 5'd3)) begin
      w_off = 12'h000;
    end else if (!status_exl && w_code == 5'd0 && cause_iv) begin
      w_off = 12'h200;
    end
  end

  assign w_base = status_bev ? 32'hBFC0_0200 : {ebase, 12'h000};

  always_comb begin
    if (w_eret) begin
      w_target = status_erl ? error_epc : epc;
    end else begin
      w_target = w_base + {20'd0, w_off};
    end
  end

  always_comb begin
    w_kill = '0;
    for (int k = 0; k < N_LANES; k++) begin
      w_kill[k] = (LW'(k) >= w_idx);
    end
  end

  // Control FSM and registered outputs
  state_e             state_q, state_d;
  logic               flush_q, flush_d;
  logic [N_LANES-1:0] kill_q, kill_d;
  logic               rv_q, rv_d;
  logic [31:0]        rpc_q, rpc_d;
  logic [4:0]         code_q, code_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        badva_q, badva_d;
  logic               ds_q, ds_d;
  logic               eret_q, eret_d;
  logic [PW-1:0]      ip_q, ip_d;
  logic [LW-1:0]      lane_q, lane_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      flush_q <= 1'b0;
      kill_q  <= '0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      code_q  <= '0;
      pc_q    <= '0;
      badva_q <= '0;
      ds_q    <= 1'b0;
      eret_q  <= 1'b0;
      ip_q    <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      kill_q  <= kill_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      badva_q <= badva_d;
      ds_q    <= ds_d;
      eret_q  <= eret_d;
      ip_q    <= ip_d;
      lane_q  <= lane_d;
    end
  end

  always_comb begin
    state_d = state_q;
    flush_d = 1'b0;
    kill_d  = '0;
    rv_d    = rv_q;
    rpc_d   = rpc_q;
    code_d  = code_q;
    pc_d    = pc_q;
    badva_d = badva_q;
    ds_d    = ds_q;
    eret_d  = eret_q;
    ip_d    = ip_q;
    lane_d  = lane_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_any) begin
          state_d = S_REQ;
          flush_d = 1'b1;
          kill_d  = w_kill;
          rv_d    = 1'b1;
          rpc_d   = w_target;
          code_d  = w_code;
          pc_d    = l_pc;
          badva_d = w_badva;
          ds_d    = l_ds;
          eret_d  = w_eret;
          ip_d    = w_ip;
          lane_d  = w_idx;
        end else begin
          rv_d    = 1'b0;
          rpc_d   = '0;
          code_d  = '0;
          pc_d    = '0;
          badva_d = '0;
          ds_d    = 1'b0;
          eret_d  = 1'b0;
          ip_d    = '0;
          lane_d  = '0;
        end
      end
      S_REQ: begin
        if (redirect_ready) begin
          state_d = S_IDLE;
          rv_d    = 1'b0;
          rpc_d   = '0;
          code_d  = '0;
          pc_d    = '0;
          badva_d = '0;
          ds_d    = 1'b0;
          eret_d  = 1'b0;
          ip_d    = '0;
          lane_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign flush          = flush_q;
  assign kill_mask      = kill_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign exc_code       = code_q;
  assign exc_pc         = pc_q;
  assign exc_badva      = badva_q;
  assign exc_delayslot  = ds_q;
  assign exc_eret       = eret_q;
  assign exc_ip         = ip_q;
  assign exc_lane       = lane_q;
  assign busy           = (state_q == S_REQ);

endmodule

// File: tb/tb_except_arbiter.sv
// Testbench for except_arbiter: directed scenarios plus randomized traffic
// compared against a rule-level reference model.
module tb_except_arbiter;

  localparam int N    = 2;
  localparam int SYNC = 2;

  typedef struct packed {
    logic        flush;
    logic [1:0]  kill;
    logic        rv;
    logic [31:0] rpc;
    logic [4:0]  code;
    logic [31:0] pc;
    logic [31:0] badva;
    logic        ds;
    logic        eret;
    logic [7:0]  ip;
    logic        lane;
    logic        busy;
  } rec_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  lane_valid;
  logic [63:0] lane_pc;
  logic [1:0]  lane_delayslot;
  logic [1:0]  lane_exc;
  logic [9:0]  lane_code;
  logic [63:0] lane_badva;
  logic [1:0]  lane_refill;
  logic [1:0]  lane_eret;
  logic [5:0]  irq_hw;
  logic [1:0]  irq_sw;
  logic [7:0]  status_im;
  logic        status_ie, status_exl, status_erl, status_bev, cause_iv;
  logic [19:0] ebase;
  logic [31:0] epc, error_epc;
  logic        redirect_ready;
  logic        flush;
  logic [1:0]  kill_mask;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_badva;
  logic        exc_delayslot, exc_eret;
  logic [7:0]  exc_ip;
  logic [0:0]  exc_lane;
  logic        busy;

  int checks = 0;
  int errors = 0;

  rec_t       m;
  logic [5:0] hq[$];

  except_arbiter #(.N_LANES(N), .IRQ_W(6), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n),
    .lane_valid(lane_valid), .lane_pc(lane_pc),
    .lane_delayslot(lane_delayslot), .lane_exc(lane_exc),
    .lane_code(lane_code), .lane_badva(lane_badva),
    .lane_refill(lane_refill), .lane_eret(lane_eret),
    .irq_hw(irq_hw), .irq_sw(irq_sw), .status_im(status_im),
    .status_ie(status_ie), .status_exl(status_exl),
    .status_erl(status_erl), .status_bev(status_bev),
    .cause_iv(cause_iv), .ebase(ebase), .epc(epc),
    .error_epc(error_epc), .redirect_ready(redirect_ready),
    .flush(flush), .kill_mask(kill_mask),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_badva(exc_badva),
    .exc_delayslot(exc_delayslot), .exc_eret(exc_eret),
    .exc_ip(exc_ip), .exc_lane(exc_lane), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rec_t sample();
    rec_t r;
    r = {flush, kill_mask, redirect_valid, redirect_pc, exc_code,
         exc_pc, exc_badva, exc_delayslot, exc_eret, exc_ip,
         exc_lane, busy};
    return r;
  endfunction

  task automatic clr_inputs();
    lane_valid = '0; lane_pc = '0; lane_delayslot = '0;
    lane_exc = '0; lane_code = '0; lane_badva = '0;
    lane_refill = '0; lane_eret = '0; irq_hw = '0; irq_sw = '0;
    status_im = '0; status_ie = 0; status_exl = 0; status_erl = 0;
    status_bev = 0; cause_iv = 0; ebase = '0; epc = '0;
    error_epc = '0; redirect_ready = 0;
  endtask

  // Reference: who wins this cycle and what record it produces
  task automatic ref_win(output bit found, output rec_t r);
    int il, el, w;
    bit isint;
    logic [7:0]  pend;
    logic [11:0] off;
    logic [31:0] base;
    il = -1; el = -1; w = 0; r = '0; found = 0;
    for (int k = 0; k < N; k++) begin
      if (lane_valid[k] && il < 0) il = k;
      if (lane_valid[k] && (lane_exc[k] || lane_eret[k]) && el < 0) el = k;
    end
    pend = {hq[SYNC-1], irq_sw} & status_im;
    isint = status_ie && !status_exl && !status_erl && (pend != 0) &&
            il >= 0 && (el < 0 || il <= el);
    if (isint) w = il;
    else if (el >= 0) w = el;
    else return;
    found = 1;
    r.flush = 1; r.rv = 1; r.busy = 1;
    r.lane = w[0];
    r.kill = 2'b11 << w;
    r.pc = lane_pc[w*32 +: 32];
    r.ds = lane_delayslot[w];
    if (isint) begin
      r.code = 0;
      r.ip = pend;
    end else if (lane_exc[w]) begin
      r.code = lane_code[w*5 +: 5];
      r.badva = lane_badva[w*32 +: 32];
    end else begin
      r.eret = 1;
    end
    if (r.eret) begin
      r.rpc = status_erl ? error_epc : epc;
    end else begin
      if (!status_exl && !isint && lane_refill[w] && (r.code == 2 || r.code == 3))
        off = 12'h000;
      else if (!status_exl && r.code == 0 && cause_iv)
        off = 12'h200;
      else
        off = 12'h180;
      base = status_bev ? 32'hBFC00200 : {ebase, 12'h000};
      r.rpc = base + {20'd0, off};
    end
  endtask

  task automatic model_edge();
    bit   f;
    rec_t w;
    if (!rst_n) begin
      m = '0;
      hq.delete();
      for (int i = 0; i < SYNC; i++) hq.push_back(6'd0);
      return;
    end
    ref_win(f, w);
    if (!m.busy) begin
      m = f ? w : '0;
    end else begin
      m.flush = 0;
      m.kill = 0;
      if (redirect_ready) m = '0;
    end
    hq.push_front(irq_hw);
    void'(hq.pop_back());
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    clr_inputs();
    redirect_ready = 1;
    cyc();
    redirect_ready = 0;
    cyc();
  endtask

  task automatic test_reset();
    rec_t g;
    clr_inputs();
    rst_n = 1;
    #2 rst_n = 0;
    #1;
    g = sample();
    checks++;
    if (g !== '0) begin
      errors++;
      $display("FAIL reset_async got=%h want=0", g);
    end
    cyc(); cyc();
    #2 rst_n = 1;
    cyc(); cyc();
    g = sample();
    checks++;
    if (g !== '0 || g !== m) begin
      errors++;
      $display("FAIL reset_idle got=%h want=%h", g, m);
    end
  endtask

  task automatic test_single_lane1();
    rec_t g;
    clr_inputs();
    lane_valid = 2'b10;
    lane_exc = 2'b10;
    lane_code[9:5] = 5'd4;
    lane_pc[63:32] = 32'h8000_1004;
    lane_badva[63:32] = 32'h0040_0001;
    ebase = 20'h80000;
    cyc();
    lane_valid = 0; lane_exc = 0;
    g = sample();
    checks++;
    if (g !== m || g.flush !== 1 || g.kill !== 2'b10 ||
        g.rpc !== 32'h8000_0180 || g.badva !== 32'h0040_0001 ||
        g.lane !== 1'b1 || g.pc !== 32'h8000_1004) begin
      errors++;
      $display("FAIL single_lane1 got=%h want=%h", g, m);
    end
    cyc();
    g = sample();
    checks++;
    if (g !== m || g.flush !== 0 || g.kill !== 0 || g.rv !== 1) begin
      errors++;
      $display("FAIL flush_one_cycle got=%h want=%h", g, m);
    end
    redirect_ready = 1;
    cyc();
    redirect_ready = 0;
    g = sample();
    checks++;
    if (g !== m || g !== '0) begin
      errors++;
      $display("FAIL release_idle got=%h want=%h", g, m);
    end
  endtask

  task automatic test_simultaneous();
    rec_t g;
    clr_inputs();
    lane_valid = 2'b11;
    lane_exc = 2'b11;
    lane_code = {5'd8, 5'd10};
    lane_pc = {32'h0000_2004, 32'h0000_2000};
    lane_delayslot = 2'b01;
    ebase = 20'h12345;
    cyc();
    g = sample();
    checks++;
    if (g !== m || g.code !== 5'd10 || g.kill !== 2'b11 ||
        g.lane !== 1'b0 || g.ds !== 1'b1 || g.rpc !== 32'h1234_5180) begin
      errors++;
      $display("FAIL simultaneous got=%h want=%h", g, m);
    end
    drain();
  endtask

  task automatic test_interrupt();
    rec_t g;
    clr_inputs();
    irq_hw = 6'b000001;
    status_im = 8'h04;
    status_ie = 1; cause_iv = 1; status_bev = 1;
    cyc(); cyc();
    g = sample();
    checks++;
    if (g !== m || g.rv !== 0) begin
      errors++;
      $display("FAIL irq_no_lane got=%h want=%h", g, m);
    end
    lane_valid = 2'b11;
    lane_exc = 2'b10;
    lane_code[9:5] = 5'd12;
    lane_pc = {32'h0000_3004, 32'h0000_3000};
    cyc();
    g = sample();
    checks++;
    if (g !== m || g.code !== 0 || g.lane !== 0 ||
        g.rpc !== 32'hBFC0_0400 || g.ip !== 8'h04 ||
        g.pc !== 32'h0000_3000 || g.flush !== 1) begin
      errors++;
      $display("FAIL interrupt got=%h want=%h", g, m);
    end
    drain();
    cyc(); cyc();
  endtask

  task automatic test_eret_refill();
    rec_t g;
    clr_inputs();
    lane_valid = 2'b01;
    lane_eret = 2'b01;
    status_erl = 1;
    error_epc = 32'hBFC0_0000;
    epc = 32'h8000_0040;
    lane_badva[31:0] = 32'hDEAD_BEEF;
    cyc();
    g = sample();
    checks++;
    if (g !== m || g.rpc !== 32'hBFC0_0000 || g.eret !== 1 ||
        g.badva !== 0) begin
      errors++;
      $display("FAIL eret got=%h want=%h", g, m);
    end
    drain();
    lane_valid = 2'b01;
    lane_exc = 2'b01;
    lane_code[4:0] = 5'd3;
    lane_refill = 2'b01;
    lane_badva[31:0] = 32'h0000_1000;
    status_bev = 1;
    cyc();
    g = sample();
    checks++;
    if (g !== m || g.rpc !== 32'hBFC0_0200 || g.code !== 5'd3 ||
        g.badva !== 32'h0000_1000) begin
      errors++;
      $display("FAIL refill got=%h want=%h", g, m);
    end
    drain();
  endtask

  task automatic test_handshake();
    rec_t g, s;
    clr_inputs();
    lane_valid = 2'b01;
    lane_exc = 2'b01;
    lane_code[4:0] = 5'd12;
    ebase = 20'hA0000;
    cyc();
    s = sample();
    checks++;
    if (s !== m || s.flush !== 1 || s.code !== 5'd12) begin
      errors++;
      $display("FAIL hs_capture got=%h want=%h", s, m);
    end
    s.flush = 0;
    s.kill = 0;
    for (int i = 0; i < 5; i++) begin
      lane_valid = 2'($urandom) | 2'b01;
      lane_exc = 2'($urandom);
      lane_code = 10'($urandom);
      lane_pc = {$urandom, $urandom};
      cyc();
      g = sample();
      checks++;
      if (g !== m || g !== s || g.busy !== 1 || g.flush !== 0) begin
        errors++;
        $display("FAIL hs_hold%0d got=%h want=%h", i, g, s);
      end
    end
    lane_valid = 2'b01;
    lane_exc = 2'b01;
    lane_code[4:0] = 5'd5;
    redirect_ready = 1;
    cyc();
    redirect_ready = 0;
    g = sample();
    checks++;
    if (g !== m || g !== '0) begin
      errors++;
      $display("FAIL hs_release got=%h want=%h", g, m);
    end
    cyc();
    g = sample();
    checks++;
    if (g !== m || g.flush !== 1 || g.code !== 5'd5) begin
      errors++;
      $display("FAIL hs_reflush got=%h want=%h", g, m);
    end
    drain();
  endtask

  task automatic test_reset_mid_req();
    rec_t g;
    clr_inputs();
    lane_valid = 2'b10;
    lane_exc = 2'b10;
    lane_code[9:5] = 5'd7;
    cyc();
    clr_inputs();
    #2 rst_n = 0;
    #1;
    g = sample();
    checks++;
    if (g !== '0) begin
      errors++;
      $display("FAIL reset_req_async got=%h want=0", g);
    end
    cyc();
    #3 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      g = sample();
      checks++;
      if (g !== m || g.rv !== 0) begin
        errors++;
        $display("FAIL reset_req_idle%0d got=%h want=%h", i, g, m);
      end
    end
  endtask

  task automatic test_random();
    rec_t g;
    clr_inputs();
    for (int i = 0; i < 400; i++) begin
      lane_valid = 2'($urandom);
      lane_exc = 2'($urandom) & 2'($urandom);
      lane_eret = 2'($urandom) & 2'($urandom);
      lane_code = 10'($urandom);
      lane_pc = {$urandom, $urandom};
      lane_badva = {$urandom, $urandom};
      lane_refill = 2'($urandom);
      lane_delayslot = 2'($urandom);
      if ($urandom_range(0, 4) == 0) irq_hw = 6'($urandom);
      irq_sw = 2'($urandom);
      status_im = 8'($urandom);
      status_ie = 1'($urandom);
      status_exl = ($urandom_range(0, 3) == 0);
      status_erl = ($urandom_range(0, 5) == 0);
      status_bev = 1'($urandom);
      cause_iv = 1'($urandom);
      ebase = 20'($urandom);
      epc = $urandom;
      error_epc = $urandom;
      redirect_ready = ($urandom_range(0, 9) < 4);
      cyc();
      g = sample();
      checks++;
      if (g !== m) begin
        errors++;
        $display("FAIL random%0d got=%h want=%h", i, g, m);
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_lane1();
    test_simultaneous();
    test_interrupt();
    test_eret_refill();
    test_handshake();
    test_reset_mid_req();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/except_arbiter.md
# except_arbiter

Multi-lane exception arbiter for the memory stage of the dual/multi-issue pipeline. It selects the oldest excepting lane or a pending interrupt, computes the exception vector or ERET target, and registers the result. It issues a one-cycle pipeline flush, then holds a redirect request to the fetch unit until that request is accepted. Hardware interrupt lines are synchronised internally, and no new exception is accepted while a redirect is outstanding.

## Interface
- N_LANES, 2, issue lanes; lane 0 is oldest in program order
- IRQ_W, 6, hardware interrupt lines (IP[7:2])
- SYNC_STAGES, 2, synchroniser depth on irq_hw, ≥2
- clk  in  1  core clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- lane_valid  in  N_LANES  lane holds a live instruction
- lane_pc  in  32*N_LANES  lane PC
- lane_delayslot  in  N_LANES  instruction is in a delay slot
- lane_exc  in  N_LANES  lane has an exception, already prioritised upstream
- lane_code  in  5*N_LANES  ExcCode for lane_exc
- lane_badva  in  32*N_LANES  bad address for address/TLB exceptions
- lane_refill  in  N_LANES  TLB miss (refill) rather than invalid
- lane_eret  in  N_LANES  lane is ERET
- irq_hw  in  IRQ_W  asynchronous hardware interrupts
- irq_sw  in  2  Cause.IP[1:0]
- status_im  in  IRQ_W+2  Status.IM
- status_ie, status_exl, status_erl, status_bev, cause_iv  in  1 each  CP0 bits
- ebase  in  20  EBase[31:12]
- epc, error_epc  in  32 each  CP0 EPC / ErrorEPC
- redirect_ready  in  1  fetch unit accepts redirect
- flush  out  1  one-cycle pipeline flush pulse
- kill_mask  out  N_LANES  lanes to squash; valid with flush
- redirect_valid  out  1  redirect request pending
- redirect_pc  out  32  handler vector or ERET target
- exc_code, exc_pc, exc_badva, exc_delayslot, exc_eret  out  5/32/32/1/1  CP0 update record
- exc_ip  out  IRQ_W+2  masked pending interrupts, for the INT case
- exc_lane  out  $clog2(N_LANES) (min 1)  winning lane
- busy  out  1  state is REQ

## Operation
- **Interrupt synchroniser.**
  - irq_hw passes through SYNC_STAGES flops to give irq_s.
  - pend = {irq_s, irq_sw} & status_im.
  - int_ok = status_ie & ~status_exl & ~status_erl & |pend.
- **Lane selection.**
  - Candidate lanes: lane_valid & (lane_exc | lane_eret).
  - e_lane = lowest-index candidate.
  - i_lane = lowest-index valid lane; it is eligible only when int_ok.
- **Winner.**
  - If the interrupt is eligible and i_lane ≤ e_lane (or there is no candidate), the interrupt wins on i_lane: code 0, eret 0.
  - Otherwise e_lane wins. lane_exc takes precedence over lane_eret; eret is set only when lane_exc=0.
- **Target computation.**
  - eret: status_erl ? error_epc : epc.
  - Otherwise offset:
    - 0x000 when exl=0, refill=1 and code ∈ {2,3}.
    - 0x200 when exl=0, code=0 and cause_iv.
    - 0x180 in all other cases.
  - base = status_bev ? 0xBFC00200 : {ebase, 12'h000}; redirect_pc = base + offset.
- **Captured fields.**
  - exc_pc = pc of the winning lane. exc_badva = that lane's lane_badva for exceptions; 0 for interrupt and eret.
  - kill_mask bit k = 1 for every k ≥ winner lane.
- **FSM.**
  - IDLE:
    - With a winner: capture all outputs, then go to REQ.
    - Without a winner: stay in IDLE and clear all outputs except busy, which stays 0.
  - REQ:
    - Inputs are ignored and lane exceptions are not recorded.
    - Interrupts remain pending in pend and are re-evaluated after return to IDLE.
    - On redirect_ready, go to IDLE.

## Timing
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - Every output goes to 0.
  - Synchroniser flops are cleared.
- Latency: a winner present at the edge ending cycle t gives flush=1, redirect_valid=1 and valid record outputs in cycle t+1.
- flush is high in cycle t+1 only. kill_mask is valid only while flush=1 and is 0 otherwise.
- Handshake: redirect_valid and all record fields stay stable until the cycle where redirect_valid & redirect_ready.
  - State returns to IDLE on the next edge.
  - Earliest next capture: inputs at t+2, seen in outputs at t+3.
  - redirect_ready in IDLE is ignored.
- Interrupt latency: an irq_hw edge is visible in pend SYNC_STAGES cycles later. Interrupts deasserted during REQ are not taken.
- Reset asserted in REQ aborts the request. No redirect_valid after reset release until a new winner arrives.
- No winner in IDLE: outputs stay 0 indefinitely.

## Test plan
- **Single exception, lane 1.**
  - Stimulus: lane 1 valid, exc=1, code=4, badva=0x00400001, bev=0, ebase=0x80000, exl=0.
  - Required: flush pulse one cycle later, kill_mask=2'b10, redirect_pc=0x80000180, exc_badva=0x00400001, exc_lane=1.
- **Simultaneous lanes.**
  - Stimulus: lane 0 code=10 and lane 1 code=8 in the same cycle.
  - Required: lane 0 wins, exc_code=10, kill_mask=2'b11.
- **Interrupt vs lane-1 exception.**
  - Stimulus: irq_hw[0]=1, IM=0x04, IE=1, iv=1, bev=1; lane 0 clean, lane 1 exc.
  - Required: after SYNC_STAGES+1 cycles, exc_code=0, exc_lane=0, redirect_pc=0xBFC00400, exc_ip=0x04.
- **ERET and TLB refill.**
  - Stimulus: eret with erl=1, error_epc=0xBFC00000.
  - Required: redirect_pc=0xBFC00000, exc_eret=1.
  - Stimulus: TLBS refill (code 3) with exl=0, bev=1.
  - Required: redirect_pc=0xBFC00200.
- **Handshake hold.**
  - Stimulus: hold redirect_ready=0 for 5 cycles while injecting new exceptions.
  - Required: outputs stable, busy=1, no second flush. redirect_ready=1 returns to IDLE; a still-present exception produces a new flush 2 cycles after the ready cycle.
- **Reset mid-REQ.**
  - Stimulus: drive rst_n low asynchronously in REQ.
  - Required: all outputs 0 immediately. After release, with no winner, redirect_valid stays 0.
